// File: rtl/signext_arbiter.sv
// signext_arbiter: one registered IN_W->OUT_W immediate extender shared by two
// requesters (0: instruction decode, 1: branch-offset unit). A round-robin
// arbiter grants one request at a time, an IDLE/EXT/RESP FSM sequences capture,
// extension and hand-off, and the result is held on a valid/ready port.
// Optional feature macro: SIGNEXT_ARB_ZX_EN adds per-requester zero-extend
// selects zx0/zx1; without it every request is sign-extended.
module signext_arbiter #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [IN_W-1:0]  imm0,
   output logic             gnt0,
   input  logic             req1,
   input  logic [IN_W-1:0]  imm1,
   output logic             gnt1,
`ifdef SIGNEXT_ARB_ZX_EN
   input  logic             zx0,
   input  logic             zx1,
`endif
   output logic [OUT_W-1:0] result,
   output logic             result_id,
   output logic             result_valid,
   input  logic             result_ready,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXT  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic            last_id;   // requester granted most recently
   logic            id_q;      // owner of the captured immediate
   logic [IN_W-1:0] imm_q;
   logic            win1;      // requester 1 wins arbitration this cycle
   logic            grant_any;
   logic            fill_bit;

`ifdef SIGNEXT_ARB_ZX_EN
   logic            zx_q;
`endif

   // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
   always_comb begin
      win1      = req1 & (~req0 | ~last_id);
      grant_any = req0 | req1;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values and updates together.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and grant decode; grants only in IDLE and never while in reset.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value
      // unassigned, which would otherwise infer a latch.
      state_nxt = state;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      case (state)
         IDLE: begin
            if (grant_any && rst_n) begin
               gnt0      = ~win1;
               gnt1      = win1;
               state_nxt = EXT;
            end
         end
         EXT:  state_nxt = RESP;
         RESP: if (result_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Fill bit for the upper result bits: sign of the immediate, or zero when
   // zero-extension was captured with the request.
   always_comb begin
`ifdef SIGNEXT_ARB_ZX_EN
      fill_bit = imm_q[IN_W-1] & ~zx_q;
`else
      fill_bit = imm_q[IN_W-1];
`endif
   end

   // Datapath: capture the winner at grant, extend in EXT, hold through RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imm_q     <= '0;
         id_q      <= 1'b0;
         last_id   <= 1'b1;   // requester 0 takes the first tie
         result    <= '0;
         result_id <= 1'b0;
`ifdef SIGNEXT_ARB_ZX_EN
         zx_q      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  imm_q   <= win1 ? imm1 : imm0;
                  id_q    <= win1;
                  last_id <= win1;
`ifdef SIGNEXT_ARB_ZX_EN
                  zx_q    <= win1 ? zx1 : zx0;
`endif
               end
            end
            EXT: begin
               result    <= {{(OUT_W-IN_W){fill_bit}}, imm_q};
               result_id <= id_q;
            end
            default: ;
         endcase
      end
   end

   // Status outputs follow the state register directly, so reset clears them at once.
   always_comb begin
      result_valid = (state == RESP);
      busy         = (state != IDLE);
   end

endmodule
